// File: rtl/adc_frame_capture.sv
// Triggered multi-channel capture buffer for deserialised ADC samples.
// Every channel is recorded into its own ring buffer once armed. A level
// crossing or a software trigger freezes one frame of DEPTH samples per
// channel, made of pre-trigger history followed by post-trigger data.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not recording; waiting for arm
// PRE   | recording; filling the pre-trigger history, triggers ignored
// ARMED | recording; waiting for a level crossing or sw_trigger
// POST  | recording; counting down the post-trigger samples
// DONE  | frame frozen; readout allowed; arm restarts the capture
module adc_frame_capture #(
    parameter  int NUM_CHANNELS = 4,
    parameter  int DATA_WIDTH   = 12,
    parameter  int DEPTH        = 256,
    localparam int ADDR_W       = $clog2(DEPTH),
    localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CHANNELS-1:0]            ch_enable,
    input  logic                               arm,
    input  logic                               abort,
    input  logic                               sw_trigger,
    input  logic                               trig_en,
    input  logic                               trig_rising,
    input  logic [CH_W-1:0]                    trig_ch,
    input  logic [DATA_WIDTH-1:0]              trig_level,
    input  logic [ADDR_W-1:0]                  pre_samples,
    input  logic [CH_W-1:0]                    rd_ch,
    input  logic                               rd_restart,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_valid,
    output logic                               rd_last,
    output logic [2:0]                         state,
    output logic                               done
);

    // One extra bit: the post-trigger countdown can start at DEPTH.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              st_q, st_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pre_q, pre_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_idx;
    logic [ADDR_W-1:0]   rd_addr;
    logic                arm_go;

    logic [DATA_WIDTH-1:0] mem [NUM_CHANNELS][DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;
    logic [CH_W-1:0]       trig_ch_q;
    logic                  ch_changed;
    logic                  hist_ok;
    logic                  level_hit;
    logic                  trig_hit;
    logic                  wr_en;
    logic                  rd_fire;

    assign wr_en = s_valid && (st_q == S_PRE || st_q == S_ARMED || st_q == S_POST);

    // Level trigger watches the raw input, independent of ch_enable.
    assign cur        = s_data[int'(trig_ch)*DATA_WIDTH +: DATA_WIDTH];
    assign ch_changed = (trig_ch != trig_ch_q);
    assign hist_ok    = prev_valid && !ch_changed;
    assign level_hit  = wr_en && trig_en && hist_ok &&
                        (trig_rising ? (prev <  trig_level && cur >= trig_level)
                                     : (prev >= trig_level && cur <  trig_level));
    assign trig_hit   = (st_q == S_ARMED) && (sw_trigger || level_hit);

    assign rd_fire = (st_q == S_DONE) && rd_en && !rd_restart;
    assign rd_addr = trig_addr_q - pre_q + rd_idx;

    assign state   = st_q;
    assign done    = (st_q == S_DONE);
    assign rd_data = rd_valid ? rd_q : '0;

    // Next-state, countdown and latch logic for the capture sequencer.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        trig_addr_d = trig_addr_q;
        arm_go      = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (arm) arm_go = 1'b1;
            end
            S_PRE: begin
                if (wr_en) begin
                    if (cnt_q == CNT_W'(1)) st_d = S_ARMED;
                    else                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ARMED: begin
                if (trig_hit) begin
                    trig_addr_d = wr_ptr;
                    if (wr_en) begin
                        // Trigger sample is being written now, so it counts.
                        if (pre_q == ADDR_W'(DEPTH - 1)) begin
                            st_d = S_DONE;
                        end else begin
                            st_d  = S_POST;
                            cnt_d = CNT_W'(DEPTH - 1) - CNT_W'(pre_q);
                        end
                    end else begin
                        st_d  = S_POST;
                        cnt_d = CNT_W'(DEPTH) - CNT_W'(pre_q);
                    end
                end
            end
            S_POST: begin
                if (wr_en) begin
                    if (cnt_q == CNT_W'(1)) st_d = S_DONE;
                    else                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (arm) arm_go = 1'b1;
            end
            default: st_d = S_IDLE;
        endcase
        if (arm_go) begin
            pre_d = pre_samples;
            cnt_d = CNT_W'(pre_samples);
            st_d  = (pre_samples == '0) ? S_ARMED : S_PRE;
        end
        if (abort) begin
            st_d   = S_IDLE;
            cnt_d  = '0;
            arm_go = 1'b0;
        end
    end

    // Sequencer registers and write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= S_IDLE;
            cnt_q       <= '0;
            pre_q       <= '0;
            trig_addr_q <= '0;
            wr_ptr      <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            trig_addr_q <= trig_addr_d;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Previous trigger-channel sample used for crossing detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_ch_q  <= '0;
        end else begin
            trig_ch_q <= trig_ch;
            if (arm_go) begin
                prev_valid <= 1'b0;
            end else if (wr_en) begin
                prev       <= cur;
                prev_valid <= 1'b1;
            end else if (ch_changed) begin
                prev_valid <= 1'b0;
            end
        end
    end

    // Sample storage: all channels written in lockstep, one registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                mem[c][wr_ptr] <= ch_enable[c] ? s_data[c*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
        end
        if (rd_fire) rd_q <= mem[rd_ch][rd_addr];
    end

    // Readout index, valid and last flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            rd_last  <= rd_fire && (rd_idx == ADDR_W'(DEPTH - 1));
            if (st_d == S_DONE && st_q != S_DONE) rd_idx <= '0;
            else if (rd_restart)                  rd_idx <= '0;
            else if (rd_fire)                     rd_idx <= rd_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: reset, level and software triggers,
// channel masking, readout sequencing, abort and re-arm.
module tb_adc_frame_capture;

    localparam int NCH   = 4;
    localparam int DW    = 12;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [NCH*DW-1:0] s_data;
    logic [NCH-1:0]    ch_enable;
    logic              arm, abort, sw_trigger, trig_en, trig_rising;
    logic [1:0]        trig_ch;
    logic [DW-1:0]     trig_level;
    logic [AW-1:0]     pre_samples;
    logic [1:0]        rd_ch;
    logic              rd_restart, rd_en;
    logic [DW-1:0]     rd_data;
    logic              rd_valid, rd_last;
    logic [2:0]        state;
    logic              done;

    int checks = 0;
    int passed = 0;

    logic [DW-1:0] got [DEPTH];
    logic          vld [DEPTH];
    logic          lst [DEPTH];

    always #5 clk = ~clk;

    adc_frame_capture #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .ch_enable(ch_enable),
        .arm(arm), .abort(abort), .sw_trigger(sw_trigger), .trig_en(trig_en),
        .trig_rising(trig_rising), .trig_ch(trig_ch), .trig_level(trig_level),
        .pre_samples(pre_samples), .rd_ch(rd_ch), .rd_restart(rd_restart), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .state(state), .done(done)
    );

    // Channel c carries a ramp of 0x010 per sample, offset by (c-1)*0x100, 12-bit wrap.
    function automatic logic [DW-1:0] sample(input int c, input int k);
        int v;
        v = k * 16 + (c - 1) * 256;
        return v[DW-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input int k);
        s_valid = 1'b1;
        for (int c = 0; c < NCH; c++) s_data[c*DW +: DW] = sample(c, k);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic write_range(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) write_sample(k);
    endtask

    task automatic do_arm(input logic [AW-1:0] pre);
        pre_samples = pre;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic read_frame(input logic [1:0] ch, input int n);
        rd_ch = ch;
        rd_restart = 1'b1;
        tick();
        rd_restart = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            got[i] = rd_data;
            vld[i] = rd_valid;
            lst[i] = rd_last;
        end
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        int nv, nl;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; ch_enable = '1;
        arm = 1'b0; abort = 1'b0; sw_trigger = 1'b0; trig_en = 1'b0; trig_rising = 1'b1;
        trig_ch = 2'd1; trig_level = 12'h800; pre_samples = '0;
        rd_ch = '0; rd_restart = 1'b0; rd_en = 1'b0;
        repeat (3) tick();
        check("reset_state", state, 3'd0);
        check("reset_done", done, 1'b0);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_rd_last", rd_last, 1'b0);
        check("reset_rd_data", rd_data, 12'h000);
        rst = 1'b0;
        tick();

        // Reset in the middle of POST.
        do_arm(8'd4);
        check("t1_pre", state, 3'd1);
        write_range(0, 3);
        check("t1_armed", state, 3'd2);
        sw_trigger = 1'b1;
        tick();
        sw_trigger = 1'b0;
        check("t1_post", state, 3'd3);
        write_range(4, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t1_rst_state", state, 3'd0);
        check("t1_rst_done", done, 1'b0);
        check("t1_rst_rd_valid", rd_valid, 1'b0);
        write_range(0, 19);
        check("t1_idle_ignores_valid", state, 3'd0);

        // Rising level trigger on channel 1, pre=16.
        trig_ch = 2'd1; trig_rising = 1'b1; trig_level = 12'h800; trig_en = 1'b1; ch_enable = 4'b1111;
        do_arm(8'd16);
        check("t2_pre", state, 3'd1);
        write_range(0, 14);
        check("t2_pre_hold", state, 3'd1);
        write_sample(15);
        check("t2_armed", state, 3'd2);
        write_range(16, 127);
        check("t2_no_early_trig", state, 3'd2);
        write_sample(128);
        check("t2_trig", state, 3'd3);
        write_range(129, 366);
        check("t2_post_hold", state, 3'd3);
        check("t2_not_done", done, 1'b0);
        write_sample(367);
        check("t2_done_state", state, 3'd4);
        check("t2_done", done, 1'b1);

        read_frame(2'd1, 20);
        read_frame(2'd1, 256);
        check("t5_restart_idx0", got[0], 12'h700);
        check("t2_idx15", got[15], 12'h7F0);
        check("t2_idx16", got[16], 12'h800);
        nv = 0; nl = 0;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t2_ch1_idx%0d", i), got[i], sample(1, 112 + i));
            if (vld[i]) nv++;
            if (lst[i]) nl++;
        end
        check("t5_valid_count", nv, 256);
        check("t5_last_count", nl, 1);
        check("t5_last_pos", lst[255], 1'b1);
        read_frame(2'd3, 256);
        check("t2_ch3_idx0", got[0], 12'h900);
        check("t2_ch3_idx16", got[16], 12'hA00);

        // Software trigger on the first ARMED cycle with pre=0.
        do_arm(8'd0);
        check("t3_armed_from_done", state, 3'd2);
        sw_trigger = 1'b1;
        rd_en = 1'b1;
        tick();
        sw_trigger = 1'b0;
        rd_en = 1'b0;
        check("t3_post", state, 3'd3);
        check("t5_rd_in_armed", rd_valid, 1'b0);
        write_range(0, 254);
        check("t3_post_hold", state, 3'd3);
        write_sample(255);
        check("t3_done", state, 3'd4);
        read_frame(2'd1, 256);
        check("t3_ch1_idx0", got[0], 12'h000);
        check("t3_ch1_idx100", got[100], 12'h640);
        check("t3_ch1_idx255", got[255], 12'hFF0);
        read_frame(2'd0, 256);
        check("t3_ch0_idx0", got[0], 12'hF00);

        // Falling trigger on channel 3, channel 2 masked, pre=8.
        trig_ch = 2'd3; trig_rising = 1'b0; trig_level = 12'h800; ch_enable = 4'b1011;
        do_arm(8'd8);
        check("t6_arm_from_done_pre", state, 3'd1);
        write_range(0, 3);
        do_arm(8'd0);
        check("t4_extra_arm_ignored", state, 3'd1);
        write_range(4, 7);
        check("t4_armed", state, 3'd2);
        write_range(8, 223);
        check("t4_no_early_trig", state, 3'd2);
        write_sample(224);
        check("t4_trig", state, 3'd3);
        write_range(225, 470);
        check("t4_post_hold", state, 3'd3);
        write_sample(471);
        check("t4_done", state, 3'd4);
        read_frame(2'd2, 256);
        for (int i = 0; i < DEPTH; i++) check($sformatf("t4_ch2_zero%0d", i), got[i], 12'h000);
        read_frame(2'd3, 256);
        check("t4_ch3_idx7", got[7], 12'hFF0);
        check("t4_ch3_idx8", got[8], 12'h000);
        read_frame(2'd0, 256);
        check("t4_ch0_idx8", got[8], 12'hD00);
        read_frame(2'd1, 256);
        check("t4_ch1_idx0", got[0], 12'hD80);
        check("t4_ch1_idx8", got[8], 12'hE00);

        // abort wins over arm while ARMED.
        do_arm(8'd0);
        check("t6_armed", state, 3'd2);
        abort = 1'b1;
        arm = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        check("t6_abort_state", state, 3'd0);
        check("t6_abort_done", done, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
